// File: rtl/sdr_mon_pkg.sv
// Shared command encoding, error bit positions and counter selects for the
// SDRAM command-bus monitor.
package sdr_mon_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5,
        CMD_MRS = 3'd6,
        CMD_BST = 3'd7
    } cmd_e;

    localparam int ERR_CLOSED   = 0;
    localparam int ERR_ACT_OPEN = 1;
    localparam int ERR_RCD      = 2;
    localparam int ERR_RP       = 3;
    localparam int ERR_RAS      = 4;
    localparam int ERR_RFC      = 5;
    localparam int ERR_REF_OPEN = 6;
    localparam int ERR_SAT      = 7;

    localparam logic [2:0] CNT_ACT = 3'd0;
    localparam logic [2:0] CNT_RD  = 3'd1;
    localparam logic [2:0] CNT_WR  = 3'd2;
    localparam logic [2:0] CNT_PRE = 3'd3;
    localparam logic [2:0] CNT_REF = 3'd4;
    localparam logic [2:0] CNT_MRS = 3'd5;
    localparam logic [2:0] CNT_BST = 3'd6;
    localparam logic [2:0] CNT_ERR = 3'd7;

    // Clock-disabled or deselected cycles never carry a command.
    function automatic cmd_e decode_cmd(input logic cke, input logic cs_n,
                                        input logic ras_n, input logic cas_n,
                                        input logic we_n);
        if (!cke || cs_n) return CMD_NOP;
        case ({ras_n, cas_n, we_n})
            3'b011:  return CMD_ACT;
            3'b101:  return CMD_RD;
            3'b100:  return CMD_WR;
            3'b010:  return CMD_PRE;
            3'b001:  return CMD_REF;
            3'b000:  return CMD_MRS;
            3'b110:  return CMD_BST;
            default: return CMD_NOP;
        endcase
    endfunction

endpackage

// File: rtl/sdr_bank_tracker.sv
// Per-bank open/closed state and tRCD/tRP/tRAS timers, flagging protocol
// violations of the command currently on the bus for this bank.
module sdr_bank_tracker
    import sdr_mon_pkg::*;
#(
    parameter int T_RCD = 3,
    parameter int T_RP  = 3,
    parameter int T_RAS = 6,
    parameter int TW    = 4
) (
    input  logic clk,
    input  logic reset,
    input  cmd_e cmd,
    input  logic bank_hit,
    input  logic pre_all,
    output logic is_open,
    output logic err_closed,
    output logic err_act_open,
    output logic err_rcd,
    output logic err_rp,
    output logic err_ras
);

    localparam logic [TW-1:0] RCD_LD = TW'(T_RCD - 1);
    localparam logic [TW-1:0] RP_LD  = TW'(T_RP - 1);
    localparam logic [TW-1:0] RAS_LD = TW'(T_RAS - 1);

    logic [TW-1:0] rcd;
    logic [TW-1:0] rp;
    logic [TW-1:0] ras;
    logic          access;
    logic          act;
    logic          pre;

    // A precharge of a closed bank is a legal no-op, so it only counts when open.
    always_comb begin
        access       = bank_hit && (cmd == CMD_RD || cmd == CMD_WR);
        act          = bank_hit && (cmd == CMD_ACT);
        pre          = (cmd == CMD_PRE) && (bank_hit || pre_all) && is_open;
        err_closed   = access && !is_open;
        err_rcd      = access && is_open && (rcd != '0);
        err_act_open = act && is_open;
        err_rp       = act && (rp != '0);
        err_ras      = pre && (ras != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            is_open <= 1'b0;
            rcd     <= '0;
            rp      <= '0;
            ras     <= '0;
        end else begin
            rcd <= (rcd != '0) ? rcd - TW'(1) : rcd;
            rp  <= (rp  != '0) ? rp  - TW'(1) : rp;
            ras <= (ras != '0) ? ras - TW'(1) : ras;
            if (act) begin
                is_open <= 1'b1;
                rcd     <= RCD_LD;
                ras     <= RAS_LD;
            end else if (pre) begin
                is_open <= 1'b0;
                rp      <= RP_LD;
            end
        end
    end

endmodule

// File: rtl/sdr_cmd_monitor.sv
// Passive SDRAM command-bus monitor: decodes commands, tracks banks, checks
// timing/protocol and keeps sticky error flags and saturating counters.
module sdr_cmd_monitor
    import sdr_mon_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int BA_W      = $clog2(NUM_BANKS),
    parameter int SDR_AW    = 13,
    parameter int T_RCD     = 3,
    parameter int T_RP      = 3,
    parameter int T_RAS     = 6,
    parameter int T_RFC     = 8,
    parameter int TW        = 4,
    parameter int CNT_W     = 16
) (
    input  logic              sdram_clk,
    input  logic              sdram_reset,
    input  logic              mon_en,
    input  logic              sdr_cke,
    input  logic              sdr_cs_n,
    input  logic              sdr_ras_n,
    input  logic              sdr_cas_n,
    input  logic              sdr_we_n,
    input  logic [BA_W-1:0]   sdr_ba,
    input  logic [SDR_AW-1:0] sdr_addr,
    input  logic              err_clr,
    input  logic [2:0]        cnt_sel,
    output logic [CNT_W-1:0]  cnt_value,
    output logic              cmd_valid,
    output logic [2:0]        cmd_code,
    output logic [BA_W-1:0]   cmd_bank,
    output logic [SDR_AW-1:0] cmd_addr,
    output logic [NUM_BANKS-1:0] bank_open,
    output logic [7:0]        err_status,
    output logic              err_pulse
);

    localparam logic [TW-1:0] RFC_LD = TW'(T_RFC - 1);

    cmd_e                 cmd_now;
    logic                 cmd_live;
    logic [TW-1:0]        rfc;
    logic [NUM_BANKS-1:0] e_closed, e_act_open, e_rcd, e_rp, e_ras;
    logic [6:0]           err_now;
    logic [7:0]           err_full;
    logic [7:0]           inc;
    logic                 sat_hit;
    logic [CNT_W-1:0]     counters [8];

    assign cmd_now  = decode_cmd(sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n);
    assign cmd_live = (cmd_now != CMD_NOP);

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        sdr_bank_tracker #(
            .T_RCD (T_RCD),
            .T_RP  (T_RP),
            .T_RAS (T_RAS),
            .TW    (TW)
        ) u_bank (
            .clk          (sdram_clk),
            .reset        (sdram_reset),
            .cmd          (cmd_now),
            .bank_hit     (sdr_ba == BA_W'(g)),
            .pre_all      (sdr_addr[10]),
            .is_open      (bank_open[g]),
            .err_closed   (e_closed[g]),
            .err_act_open (e_act_open[g]),
            .err_rcd      (e_rcd[g]),
            .err_rp       (e_rp[g]),
            .err_ras      (e_ras[g])
        );
    end

    // Error-command counting looks only at protocol errors so that the
    // saturation flag cannot feed back into its own counter.
    always_comb begin
        err_now                = '0;
        err_now[ERR_CLOSED]    = |e_closed;
        err_now[ERR_ACT_OPEN]  = |e_act_open;
        err_now[ERR_RCD]       = |e_rcd;
        err_now[ERR_RP]        = |e_rp;
        err_now[ERR_RAS]       = |e_ras;
        err_now[ERR_RFC]       = cmd_live && (rfc != '0);
        err_now[ERR_REF_OPEN]  = (cmd_now == CMD_REF) && (|bank_open);
        inc = '0;
        for (int i = 0; i < 7; i++) begin
            inc[i] = mon_en && (cmd_now == cmd_e'(3'(i + 1)));
        end
        inc[CNT_ERR] = mon_en && (|err_now);
        sat_hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sat_hit = sat_hit | (inc[i] && (&counters[i]));
        end
        err_full = {sat_hit, err_now};
    end

    assign cnt_value = counters[cnt_sel];

    always_ff @(posedge sdram_clk) begin
        if (sdram_reset) begin
            cmd_valid  <= 1'b0;
            cmd_code   <= '0;
            cmd_bank   <= '0;
            cmd_addr   <= '0;
            err_status <= '0;
            err_pulse  <= 1'b0;
            rfc        <= '0;
            for (int i = 0; i < 8; i++) counters[i] <= '0;
        end else begin
            cmd_valid  <= cmd_live;
            cmd_code   <= cmd_now;
            cmd_bank   <= sdr_ba;
            cmd_addr   <= sdr_addr;
            err_pulse  <= mon_en && (|err_full);
            err_status <= (err_clr ? 8'h00 : err_status) | (mon_en ? err_full : 8'h00);
            if (cmd_now == CMD_REF) rfc <= RFC_LD;
            else if (rfc != '0)     rfc <= rfc - TW'(1);
            for (int i = 0; i < 8; i++) begin
                if (inc[i] && !(&counters[i])) counters[i] <= counters[i] + CNT_W'(1);
            end
        end
    end

endmodule
